// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with self-timed mid-bit sampling and a valid/ack holding register
module uart_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] baud_value,
  input  logic        data_ack,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        frame_error,
  output logic        overrun,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t      state_q, state_d;
  logic        rx_m_q, rx_s_q;
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  sh_q, sh_d, data_q, data_d;
  logic        valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic        hit, half, stop_hit, done, ack;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      div_q   <= 16'd3;
      cnt_q   <= '0;
      bitn_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rx_s_q ? IDLE : START;
      START:   state_d = !half ? START : (rx_s_q ? IDLE : DATA);
      DATA:    state_d = (hit && bitn_q == 3'd7) ? STOP : DATA;
      STOP:    state_d = !hit ? STOP : (rx_s_q ? IDLE : BRK);
      BRK:     state_d = rx_s_q ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    hit      = cnt_q == div_q;
    half     = cnt_q == {1'b0, div_q[15:1]};
    stop_hit = state_q == STOP && hit;
    done     = stop_hit && rx_s_q;
    ack      = data_ack && valid_q;
    div_d    = (state_q == IDLE && !rx_s_q) ? ((baud_value < 16'd3) ? 16'd3 : baud_value) : div_q;
    cnt_d    = (state_q == IDLE || state_q == BRK || (state_q == START ? half : hit)) ? 16'd0 : cnt_q + 16'd1;
    bitn_d   = (state_q == START) ? 3'd0 : (state_q == DATA && hit) ? bitn_q + 3'd1 : bitn_q;
    sh_d     = (state_q == DATA && hit) ? {rx_s_q, sh_q[7:1]} : sh_q;
    data_d   = done ? sh_q : data_q;
    ferr_d   = stop_hit && !rx_s_q;
    // a completion in the same cycle as an ack wins, so the new byte stays valid
    valid_d  = done ? 1'b1 : ack ? 1'b0 : valid_q;
    ovr_d    = (done && valid_q && !data_ack) ? 1'b1 : ack ? 1'b0 : ovr_q;
  end
  always_comb begin
    busy        = state_q != IDLE;
    data        = data_q;
    data_valid  = valid_q;
    frame_error = ferr_q;
    overrun     = ovr_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a queue-based scoreboard checked by an independent output monitor
module tb_uart_rx;
  logic        clk = 0, reset = 0, rx = 1, data_ack = 0;
  logic [15:0] baud_value = 16'd15;
  logic [7:0]  data;
  logic        data_valid, frame_error, overrun, busy;
  int          tests = 0, fails = 0;
  logic [9:0]  exp_q[$];
  logic        prev_v = 0;
  logic [7:0]  prev_d = 0;
  logic [9:0]  e;

  uart_rx dut (.clk(clk), .reset(reset), .rx(rx), .baud_value(baud_value), .data_ack(data_ack),
               .data(data), .data_valid(data_valid), .frame_error(frame_error), .overrun(overrun), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // entry: {is_frame_error, overrun, data}
  task automatic send(input logic [7:0] b, input logic stop, input logic [15:0] bv, input logic chg);
    int p;
    p = (bv < 3 ? 3 : bv) + 1;
    baud_value = bv;
    rx = 0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (chg && i == 4) baud_value = 16'd200;
      tick(p);
    end
    rx = stop;
    tick(p);
    rx = 1;
    baud_value = bv;
  endtask

  task automatic do_ack();
    data_ack = 1;
    tick(1);
    data_ack = 0;
  endtask

  always @(negedge clk) begin
    if (reset && frame_error) begin
      if (exp_q.size() == 0) chk("unexpected frame_error", 16'd1, 16'd0);
      else begin
        e = exp_q.pop_front();
        chk("frame_error expected", {15'd0, frame_error}, {15'd0, e[9]});
      end
    end else if (reset && data_valid && (!prev_v || data != prev_d)) begin
      if (exp_q.size() == 0) chk("unexpected byte", {8'd0, data}, 16'hFFFF);
      else begin
        e = exp_q.pop_front();
        chk("byte kind", 16'd0, {15'd0, e[9]});
        chk("byte data", {8'd0, data}, {8'd0, e[7:0]});
        chk("byte overrun", {15'd0, overrun}, {15'd0, e[8]});
      end
    end
    prev_v = data_valid;
    prev_d = data;
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rx = 1'($urandom);
      tick(1);
    end
    rx = 1;
    tick(2);
    reset = 1;
    tick(1);
    chk("rst data", {8'd0, data}, 16'h0000);
    chk("rst valid", {15'd0, data_valid}, 16'd0);
    chk("rst ferr", {15'd0, frame_error}, 16'd0);
    chk("rst overrun", {15'd0, overrun}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      if (busy) chk("busy idle", 16'd1, 16'd0);
      tick(1);
    end
    chk("busy idle end", {15'd0, busy}, 16'd0);

    exp_q.push_back({2'b00, 8'hA5});
    send(8'hA5, 1, 16'd15, 0);
    tick(2);
    chk("basic valid", {15'd0, data_valid}, 16'd1);
    chk("basic data", {8'd0, data}, 16'h00A5);
    do_ack();
    chk("basic ack clears", {15'd0, data_valid}, 16'd0);

    rx = 0;
    tick(5);
    chk("false start busy", {15'd0, busy}, 16'd1);
    rx = 1;
    tick(20);
    chk("false start idle", {15'd0, busy}, 16'd0);
    chk("false start valid", {15'd0, data_valid}, 16'd0);

    exp_q.push_back({2'b10, 8'h00});
    send(8'h3C, 0, 16'd15, 0);
    rx = 0;
    tick(40);
    chk("break busy", {15'd0, busy}, 16'd1);
    chk("break valid", {15'd0, data_valid}, 16'd0);
    rx = 1;
    tick(6);
    chk("break exit", {15'd0, busy}, 16'd0);
    chk("break no byte", {15'd0, data_valid}, 16'd0);

    exp_q.push_back({2'b00, 8'h11});
    send(8'h11, 1, 16'd15, 0);
    exp_q.push_back({2'b01, 8'h22});
    send(8'h22, 1, 16'd15, 0);
    tick(2);
    chk("overrun data", {8'd0, data}, 16'h0022);
    chk("overrun flag", {15'd0, overrun}, 16'd1);
    do_ack();
    chk("overrun ack valid", {15'd0, data_valid}, 16'd0);
    chk("overrun ack flag", {15'd0, overrun}, 16'd0);

    exp_q.push_back({2'b00, 8'h55});
    send(8'h55, 1, 16'd433, 0);
    tick(2);
    do_ack();

    exp_q.push_back({2'b00, 8'h5A});
    send(8'h5A, 1, 16'd1, 0);
    tick(2);
    do_ack();

    exp_q.push_back({2'b00, 8'hC3});
    send(8'hC3, 1, 16'd15, 1);
    tick(2);
    do_ack();

    baud_value = 16'd15;
    rx = 0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      tick(16);
    end
    tick(8);
    rx = 1;
    reset = 0;
    tick(2);
    chk("mid reset valid", {15'd0, data_valid}, 16'd0);
    chk("mid reset busy", {15'd0, busy}, 16'd0);
    chk("mid reset data", {8'd0, data}, 16'h0000);
    reset = 1;
    tick(20);
    chk("mid reset no byte", {15'd0, data_valid}, 16'd0);
    exp_q.push_back({2'b00, 8'h96});
    send(8'h96, 1, 16'd15, 0);
    tick(4);
    chk("after reset data", {8'd0, data}, 16'h0096);
    chk("scoreboard drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the RS-232 path: deserialises 8N1 frames from the `rx` line into bytes and presents them on a valid/ack holding register. It is the receive counterpart to the baud-rate generator and divisor-select logic. It uses the same 16-bit `baud_value` divisor encoding, so one select decode drives both directions. The block runs on the system clock and derives its own mid-bit sample points, so no separate baud clock is needed.

## Interface
- No parameters. Frame format is fixed: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, idle high; asynchronous to `clk`.
- `baud_value` input 16: bit period minus one, in `clk` cycles (433 gives 115200 baud at 50 MHz). Captured at start-bit detection.
- `data` output 8: last received byte.
- `data_valid` output 1: high while `data` holds an unacknowledged byte.
- `data_ack` input 1: consumer strobe; clears `data_valid`.
- `frame_error` output 1: one-cycle pulse when the stop bit samples low.
- `overrun` output 1: sticky flag; a byte completed while `data_valid` was still high.
- `busy` output 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`), which resets to 1. All decisions use `rx_s`.
- Divisor: `div = max(baud_value, 3)`, latched on leaving IDLE. Changes to `baud_value` mid-frame are ignored.
- Counter `cnt` is 16 bits and bit counter `bitn` is 3 bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE, `rx_s==0`: latch `div`, set `cnt=0`, go to START.
- START, `cnt==div>>1` (mid start bit):
  - `rx_s==0`: set `cnt=0`, `bitn=0`, go to DATA.
  - `rx_s==1`: false start; return to IDLE with no outputs changed.
- START otherwise: increment `cnt`.
- DATA, `cnt==div`: shift `rx_s` into the shift register MSB (LSB-first reception), set `cnt=0`, increment `bitn`. When `bitn==7`, go to STOP.
- STOP, `cnt==div`: sample the stop bit.
  - `rx_s==1`: copy the shift register to `data`, set `data_valid=1`, go to IDLE.
  - `rx_s==0`: pulse `frame_error`, leave `data` and `data_valid` unchanged, go to BREAK.
- BREAK: wait for `rx_s==1`, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- Holding register handshake:
  - `data_ack` with `data_valid==1` clears `data_valid` on the next edge.
  - `data_ack` with `data_valid==0` is ignored.
- Byte completion while `data_valid==1`:
  - Set `overrun=1` and overwrite `data` with the new byte; `data_valid` stays 1.
  - If `data_ack` arrives in the same cycle as completion, the completion wins: `data_valid` stays 1 with the new byte, and `overrun` is not set.
- `overrun` is cleared only by `data_ack` or reset.

## Timing
- Reset values: `data=8'h00`, `data_valid=0`, `frame_error=0`, `overrun=0`, `busy=0`, FSM in IDLE, `rx_s=1`.
- Bit period is `P = div+1` clocks.
- Let T0 be the edge on which IDLE sees `rx_s==0`. This is 2–3 clocks after `rx` falls, due to the synchronizer.
- Start-bit check at T0 + (div>>1) + 1.
- Data bit k sampled at T0 + (div>>1) + 1 + (k+1)·P.
- Stop bit sampled at T0 + (div>>1) + 1 + 9·P.
- `data`/`data_valid` update on the stop-sample edge; `frame_error` is high for exactly that one cycle.
- Back-to-back frames are accepted: IDLE is re-entered about half a bit before the stop bit ends.
- Reset assertion at any point aborts the frame immediately; no partial byte is ever presented.
- `busy` rises on the edge after T0 and falls on the stop-sample edge, or on BREAK exit.

## Test plan
- Reset values: hold `reset=0` with random `rx`, then release. All outputs must be at reset values, and `busy` stays 0 while `rx=1`.
- Basic frame: `baud_value=15` (P=16), send 8'hA5 with a correct stop bit. `data=8'hA5`, `data_valid=1`, and `frame_error` never pulses. Then pulse `data_ack`: `data_valid=0` on the next cycle.
- False start: with `baud_value=15`, drive `rx` low for 5 clocks, then high. FSM returns to IDLE, `busy` drops, and `data_valid` stays 0.
- Framing error and break: send 8'h3C with the stop bit low, then hold `rx` low for 40 clocks. There is exactly one `frame_error` pulse, no `data_valid`, and no second frame starts until `rx` returns high.
- Overrun: send 8'h11, then 8'h22 without ack. `data=8'h22`, `overrun=1`. After `data_ack`, `data_valid=0` and `overrun=0`.
- Divisor handling:
  - `baud_value=433`: 8'h55 is received correctly.
  - `baud_value=1`: treated as 3, with bits 4 clocks wide.
  - Changing `baud_value` mid-frame does not corrupt the byte.
  - Reset pulsed at DATA bit 4: no output change, and the next frame is received cleanly.
